// File: rtl/seq_det_pkg.sv
// Run-of-ones detector context encoding and its shared next-state/hit function.
// Pure combinational helpers; no latency, no flow control.
package seq_det_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10
  } ctx_e;

  typedef struct packed {
    logic       hit;
    logic [1:0] nxt;
  } step_t;

  // Encoding 2'b11 is unreachable but falls back to S0 without a hit.
  function automatic step_t det_step(input logic [1:0] cur, input logic bit_i);
    step_t r;
    r.hit = 1'b0;
    r.nxt = S0;
    if (bit_i) begin
      case (cur)
        S0:      r.nxt = S1;
        S1:      r.nxt = S2;
        S2: begin
          r.nxt = S2;
          r.hit = 1'b1;
        end
        default: r.nxt = S0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant, search starting at ptr and wrapping at N-1.
// Combinational; grant is a subset of req, zero when req is zero.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic          w_found;
  logic [PW-1:0] w_idx;

  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = PW'((int'(ptr) + k) % N);
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_det_sched.sv
// Time-multiplexed run-of-three-ones detector over NCH serial requesters with hit counters.
// Detection result registered 1 cycle after transfer; one channel accepted per cycle via req_ready.
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = 8,
  parameter int CH_W  = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   req_valid,
  input  logic [NCH-1:0]   req_bit,
  output logic [NCH-1:0]   req_ready,
  input  logic             clr,
  output logic             det_valid,
  output logic [CH_W-1:0]  det_ch,
  output logic             det_hit,
  input  logic [CH_W-1:0]  rd_ch,
  output logic [CNT_W-1:0] rd_cnt
);

  logic [1:0]       r_ctx [NCH];
  logic [CNT_W-1:0] r_cnt [NCH];
  logic [CH_W-1:0]  r_ptr;
  logic             r_det_valid;
  logic [CH_W-1:0]  r_det_ch;
  logic             r_det_hit;

  logic [NCH-1:0]   w_arb_req;
  logic [NCH-1:0]   w_grant;
  logic [CH_W-1:0]  w_gidx;
  logic [CH_W-1:0]  w_ptr_nxt;
  logic             w_xfer;
  step_t            w_step;

  // clr masks the request so no grant (and thus no transfer) can be issued alongside it.
  assign w_arb_req = clr ? '0 : req_valid;

  rr_arbiter #(
    .N  (NCH),
    .PW (CH_W)
  ) u_arb (
    .req   (w_arb_req),
    .ptr   (r_ptr),
    .grant (w_grant)
  );

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_grant[i]) w_gidx = CH_W'(i);
    end
  end

  assign w_xfer    = |w_grant;
  assign w_step    = det_step(r_ctx[w_gidx], req_bit[w_gidx]);
  assign w_ptr_nxt = (w_gidx == CH_W'(NCH - 1)) ? '0 : w_gidx + CH_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        r_ctx[i] <= S0;
        r_cnt[i] <= '0;
      end
      r_ptr       <= '0;
      r_det_valid <= 1'b0;
      r_det_ch    <= '0;
      r_det_hit   <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < NCH; i++) begin
        r_ctx[i] <= S0;
        r_cnt[i] <= '0;
      end
      r_ptr       <= '0;
      r_det_valid <= 1'b0;
    end else begin
      r_det_valid <= w_xfer;
      if (w_xfer) begin
        r_ctx[w_gidx] <= w_step.nxt;
        if (w_step.hit && (r_cnt[w_gidx] != '1)) begin
          r_cnt[w_gidx] <= r_cnt[w_gidx] + CNT_W'(1);
        end
        r_ptr     <= w_ptr_nxt;
        r_det_ch  <= w_gidx;
        r_det_hit <= w_step.hit;
      end
    end
  end

  assign req_ready = w_grant;
  assign det_valid = r_det_valid;
  assign det_ch    = r_det_ch;
  assign det_hit   = r_det_hit;
  assign rd_cnt    = r_cnt[rd_ch];

endmodule

// File: doc/seq_det_sched.md
SEQ_DET_SCHED -- requirements
Module: seq_det_sched

Interface
REQ-001 Parameter NCH, default 4: number of serial-bit requester channels (2..8).
REQ-002 Parameter CNT_W, default 8: width of each per-channel hit counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  NCH  per-channel bit offered.
REQ-006 req_bit  in  NCH  per-channel serial data bit.
REQ-007 req_ready  out  NCH  one-hot grant; combinational from req_valid, pointer and clr.
REQ-008 clr  in  1  synchronous clear of all channel contexts and counters.
REQ-009 det_valid  out  1  registered; a bit was consumed last cycle.
REQ-010 det_ch  out  clog2(NCH)  channel of the consumed bit.
REQ-011 det_hit  out  1  the consumed bit completed a run of three or more consecutive ones on det_ch.
REQ-012 rd_ch  in  clog2(NCH)  counter read select.
REQ-013 rd_cnt  out  CNT_W  combinational hit count of channel rd_ch.

Function
REQ-014 A single shared run-of-ones detector SHALL be time-multiplexed across channels, with one 2-bit context register per channel.
REQ-015 Context states: S0 (no trailing one), S1 (one trailing one), S2 (two or more trailing ones).
REQ-016 Transitions on a consumed bit: S0 -1-> S1, S1 -1-> S2, S2 -1-> S2 with hit, any state -0-> S0.
REQ-017 Unused state encoding 2'b11 SHALL return to S0 with no hit.
REQ-018 At most one channel SHALL be granted per cycle; transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-019 Arbitration SHALL be round-robin: search starts at channel ptr and wraps from NCH-1 to 0.
REQ-020 After a transfer on channel g, ptr SHALL become (g+1) mod NCH; with no transfer, ptr SHALL hold.
REQ-021 req_ready SHALL be all-zero when no channel is valid or when clr is high.
REQ-022 The channel's context SHALL update only on its own transfer; other contexts hold.
REQ-023 det_valid, det_ch and det_hit SHALL be registered with 1-cycle latency after the transfer cycle.
REQ-024 det_valid SHALL be low in any cycle following a non-transfer cycle; det_ch and det_hit hold their previous values.
REQ-025 On a hit, the channel's counter SHALL increment by 1 and saturate at 2^CNT_W-1.
REQ-026 clr SHALL clear all contexts to S0, clear all counters and ptr to 0, and force det_valid low next cycle, overriding any concurrent transfer.
REQ-027 A requester holding req_valid SHALL be granted within NCH cycles (starvation-free).

Reset
REQ-028 While reset is low: all contexts S0, all counters 0, ptr 0, det_valid 0, det_ch 0, det_hit 0.
REQ-029 Assertion of reset mid-stream SHALL discard all run history; the first post-reset bits SHALL start from S0.

Structure
REQ-030 State encodings S0/S1/S2 and the next-state/hit function SHALL reside in shared package seq_det_pkg.
REQ-031 The round-robin grant logic SHALL be a separate sub-module rr_arbiter (parameter N; ports req, ptr, grant).

Verification
REQ-032 Single channel 0: bits 1,1,1,1,0,1 -> det_hit 0,0,1,1,0,0 each one cycle later; rd_cnt(0)=2.
REQ-033 All four channels valid continuously -> grants 0,1,2,3,0,... in order; each channel receives one grant per 4 cycles.
REQ-034 Interleaving: ch1 sends 1,1 and ch2 sends 1 while ch1 is idle; then ch1 sends 1 -> hit on ch1 only; ch2 context stays S1.
REQ-035 Saturation with CNT_W=2: five hits on ch3 -> rd_cnt(3)=3.
REQ-036 clr asserted in the same cycle as a transfer on ch0 in S2 with bit 1 -> no det_valid the next cycle, rd_cnt(0)=0, ch0 in S0.
REQ-037 reset low for 2 cycles mid-run on ch2 (S2) -> next bits 1,1 give no hit; the third 1 gives a hit.
